// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
//   Exception/interrupt sequencer in front of the CP0 register file.
//
//   Operation
//     - Samples the commit-stage instruction and picks the highest-priority
//       exception or pending interrupt.
//     - Drives CP0 write strobes and write data.
//     - Flushes the pipeline and redirects fetch to EXC_VECTOR, or to EPC on
//       ERET.
//     - Every output is registered.
//
//   Ports
//     clk, rst                   clock, asynchronous active-high reset
//     commit_valid/pc/bd/exc/eret commit-stage instruction
//     mem_addr                   data address of the committing load/store
//     hw_int                     raw hardware interrupt lines
//     status_in/cause_in/epc_in  current CP0 register values
//     cp0_we                     per-register write strobes
//                                (8=BadVAddr, 12=Status, 13=Cause, 14=EPC)
//     exc_code, bd_out, epc_out, badvaddr_out, exl_out   CP0 write data
//     hw_int_out                 synchronised hw_int for Cause.IP7:2
//     flush                      kill all stages younger than commit
//     redirect_valid/pc          one-cycle fetch redirect
//     busy                       sequencer not idle; commit must hold
module cp0_exc_ctrl #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [WIDTH-1:0] commit_pc,
  input  logic             commit_bd,
  input  logic [6:0]       commit_exc,
  input  logic             commit_eret,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [5:0]       hw_int,
  input  logic [31:0]      status_in,
  input  logic [31:0]      cause_in,
  input  logic [WIDTH-1:0] epc_in,
  output logic [31:0]      cp0_we,
  output logic [4:0]       exc_code,
  output logic             bd_out,
  output logic [WIDTH-1:0] epc_out,
  output logic [WIDTH-1:0] badvaddr_out,
  output logic             exl_out,
  output logic [5:0]       hw_int_out,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRAP  = 2'd1;
  localparam logic [1:0] S_RET   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  // commit_exc bit positions
  localparam int E_ADELI = 0;
  localparam int E_RI    = 1;
  localparam int E_OV    = 2;
  localparam int E_SYS   = 3;
  localparam int E_BP    = 4;
  localparam int E_ADELD = 5;
  localparam int E_ADES  = 6;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [5:0]       sync1_q, sync2_q;

  logic [31:0]      we_q, we_d;
  logic [4:0]       code_q, code_d;
  logic             bd_q, bd_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] bad_q, bad_d;
  logic             exl_q, exl_d;
  logic             flush_q, flush_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] rpc_q, rpc_d;
  logic             busy_q, busy_d;

  logic             int_pend;
  logic             take_trap;
  logic [4:0]       sel_code;
  logic             sel_bad;
  logic [WIDTH-1:0] sel_bad_addr;

  // The interrupt mask uses the synchronised lines, so a rising hw_int
  // edge becomes visible to the sequencer two clocks later.
  assign int_pend  = (|({sync2_q, cause_in[9:8]} & status_in[15:8]))
                     & status_in[0] & ~status_in[1];
  assign take_trap = int_pend | (|commit_exc);

  // Priority chain, highest first. An interrupt outranks every synchronous
  // exception.
  always_comb begin
    sel_code     = 5'd0;
    sel_bad      = 1'b0;
    sel_bad_addr = '0;
    if (int_pend) begin
      sel_code = 5'd0;
    end else if (commit_exc[E_ADELI]) begin
      sel_code     = 5'd4;
      sel_bad      = 1'b1;
      sel_bad_addr = commit_pc;
    end else if (commit_exc[E_RI]) begin
      sel_code = 5'd10;
    end else if (commit_exc[E_OV]) begin
      sel_code = 5'd12;
    end else if (commit_exc[E_SYS]) begin
      sel_code = 5'd8;
    end else if (commit_exc[E_BP]) begin
      sel_code = 5'd9;
    end else if (commit_exc[E_ADELD]) begin
      sel_code     = 5'd4;
      sel_bad      = 1'b1;
      sel_bad_addr = mem_addr;
    end else if (commit_exc[E_ADES]) begin
      sel_code     = 5'd5;
      sel_bad      = 1'b1;
      sel_bad_addr = mem_addr;
    end
  end

  // Next state and next outputs are computed together. The outputs
  // registered at an edge describe the state entered at that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = '0;
    code_d  = '0;
    bd_d    = 1'b0;
    epc_d   = '0;
    bad_d   = '0;
    exl_d   = 1'b0;
    flush_d = 1'b0;
    rv_d    = 1'b0;
    rpc_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (commit_valid) begin
          if (take_trap) begin
            state_d  = S_TRAP;
            we_d[13] = 1'b1;
            we_d[12] = 1'b1;
            exl_d    = 1'b1;
            code_d   = sel_code;
            // A nested trap (EXL already set) keeps the original EPC/BD.
            if (!status_in[1]) begin
              we_d[14] = 1'b1;
              epc_d    = commit_bd ? (commit_pc - WIDTH'(4)) : commit_pc;
              bd_d     = commit_bd;
            end
            if (sel_bad) begin
              we_d[8] = 1'b1;
              bad_d   = sel_bad_addr;
            end
            flush_d = 1'b1;
            rv_d    = 1'b1;
            rpc_d   = WIDTH'(EXC_VECTOR);
          end else if (commit_eret) begin
            state_d  = S_RET;
            we_d[12] = 1'b1;
            exl_d    = 1'b0;
            flush_d  = 1'b1;
            rv_d     = 1'b1;
            rpc_d    = epc_in;
          end
        end
      end
      S_TRAP, S_RET: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(FLUSH_CYCLES - 2);
          flush_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          flush_d = 1'b1;
        end
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      we_q    <= '0;
      code_q  <= '0;
      bd_q    <= 1'b0;
      epc_q   <= '0;
      bad_q   <= '0;
      exl_q   <= 1'b0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= hw_int;
      sync2_q <= sync1_q;
      we_q    <= we_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
      exl_q   <= exl_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      busy_q  <= busy_d;
    end
  end

  assign cp0_we         = we_q;
  assign exc_code       = code_q;
  assign bd_out         = bd_q;
  assign epc_out        = epc_q;
  assign badvaddr_out   = bad_q;
  assign exl_out        = exl_q;
  assign hw_int_out     = sync2_q;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign busy           = busy_q;

  // Only the IM/EXL/IE fields of Status and IP1:0 of Cause are consumed.
  logic unused_bits;
  assign unused_bits = ^{status_in[31:16], status_in[7:2], cause_in[31:10], cause_in[7:0]};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [6:0]  commit_exc;
  logic        commit_eret;
  logic [31:0] mem_addr;
  logic [5:0]  hw_int;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [31:0] epc_in;
  logic [31:0] cp0_we;
  logic [4:0]  exc_code;
  logic        bd_out;
  logic [31:0] epc_out;
  logic [31:0] badvaddr_out;
  logic        exl_out;
  logic [5:0]  hw_int_out;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
    .commit_exc(commit_exc), .commit_eret(commit_eret), .mem_addr(mem_addr),
    .hw_int(hw_int), .status_in(status_in), .cause_in(cause_in), .epc_in(epc_in),
    .cp0_we(cp0_we), .exc_code(exc_code), .bd_out(bd_out), .epc_out(epc_out),
    .badvaddr_out(badvaddr_out), .exl_out(exl_out), .hw_int_out(hw_int_out),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    commit_valid = 1'b0;
    commit_exc   = 7'h00;
    commit_eret  = 1'b0;
    commit_bd    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; commit_valid = 1'b1; commit_pc = 32'h0; commit_bd = 1'b0;
    commit_exc = 7'h7F; commit_eret = 1'b0; mem_addr = 32'h0; hw_int = 6'h0;
    status_in = 32'h0; cause_in = 32'h0; epc_in = 32'h0;

    // reset with every exception flag asserted
    tick(); tick();
    chk("rst_we", cp0_we, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_rv", {31'h0, redirect_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_code", {27'h0, exc_code}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    rst = 1'b0; idle_in();
    tick();
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_flush", {31'h0, flush}, 32'h0);
    $display("[TB] reset done");

    // Ov, not in delay slot, EXL=0
    commit_valid = 1'b1; commit_pc = 32'h80001000; commit_exc = 7'b0000100;
    tick();
    idle_in();
    chk("ov_we", cp0_we, 32'h00007000);
    chk("ov_code", {27'h0, exc_code}, 32'd12);
    chk("ov_epc", epc_out, 32'h80001000);
    chk("ov_bd", {31'h0, bd_out}, 32'h0);
    chk("ov_exl", {31'h0, exl_out}, 32'h1);
    chk("ov_rpc", redirect_pc, 32'hBFC00380);
    chk("ov_rv", {31'h0, redirect_valid}, 32'h1);
    chk("ov_flush1", {31'h0, flush}, 32'h1);
    chk("ov_busy1", {31'h0, busy}, 32'h1);
    tick();
    chk("ov_flush2", {31'h0, flush}, 32'h1);
    chk("ov_drain_we", cp0_we, 32'h0);
    chk("ov_drain_rv", {31'h0, redirect_valid}, 32'h0);
    chk("ov_busy2", {31'h0, busy}, 32'h1);
    tick();
    chk("ov_flush3", {31'h0, flush}, 32'h0);
    chk("ov_busy3", {31'h0, busy}, 32'h0);
    $display("[TB] Ov trap done");

    // AdELd in a delay slot
    commit_valid = 1'b1; commit_pc = 32'h80000004; commit_bd = 1'b1;
    mem_addr = 32'h00001235; commit_exc = 7'b0100000;
    tick();
    idle_in();
    chk("adeld_epc", epc_out, 32'h80000000);
    chk("adeld_bd", {31'h0, bd_out}, 32'h1);
    chk("adeld_bad", badvaddr_out, 32'h00001235);
    chk("adeld_we", cp0_we, 32'h00007100);
    chk("adeld_code", {27'h0, exc_code}, 32'd4);
    tick(); tick();
    $display("[TB] AdELd trap done");

    // RI + Sys + ERET together: RI wins, no return
    commit_valid = 1'b1; commit_pc = 32'h80000100; commit_exc = 7'b0001010;
    commit_eret = 1'b1; epc_in = 32'h80005000;
    tick();
    idle_in();
    chk("prio_code", {27'h0, exc_code}, 32'd10);
    chk("prio_exl", {31'h0, exl_out}, 32'h1);
    chk("prio_rpc", redirect_pc, 32'hBFC00380);
    tick(); tick();
    $display("[TB] priority trap done");

    // Sys with EXL already set: EPC/BD untouched
    status_in = 32'h00000002;
    commit_valid = 1'b1; commit_pc = 32'h80000200; commit_bd = 1'b1; commit_exc = 7'b0001000;
    tick();
    idle_in();
    chk("exl_we", cp0_we, 32'h00003000);
    chk("exl_code", {27'h0, exc_code}, 32'd8);
    chk("exl_bd", {31'h0, bd_out}, 32'h0);
    tick(); tick();
    status_in = 32'h0;
    $display("[TB] nested Sys trap done");

    // Interrupt on hw_int[0] (IM2), IE=1
    status_in = 32'h00000401;
    commit_valid = 1'b1; commit_pc = 32'h80003000;
    hw_int = 6'h01;
    tick();
    chk("int_c1_busy", {31'h0, busy}, 32'h0);
    chk("int_c1_sync", {26'h0, hw_int_out}, 32'h0);
    tick();
    chk("int_c2_busy", {31'h0, busy}, 32'h0);
    chk("int_c2_sync", {26'h0, hw_int_out}, 32'h1);
    tick();
    idle_in();
    chk("int_c3_busy", {31'h0, busy}, 32'h1);
    chk("int_code", {27'h0, exc_code}, 32'd0);
    chk("int_we", cp0_we, 32'h00007000);
    chk("int_epc", epc_out, 32'h80003000);
    tick(); tick();
    $display("[TB] interrupt trap done");

    // same pending line with IE=0 must not trap
    status_in = 32'h00000400;
    commit_valid = 1'b1;
    tick(); tick();
    chk("int_ie0_busy", {31'h0, busy}, 32'h0);
    chk("int_ie0_we", cp0_we, 32'h0);
    idle_in(); hw_int = 6'h0;
    $display("[TB] masked interrupt done");

    // ERET
    status_in = 32'h00000002; epc_in = 32'h80002000;
    commit_valid = 1'b1; commit_eret = 1'b1;
    tick();
    idle_in();
    chk("eret_we", cp0_we, 32'h00001000);
    chk("eret_exl", {31'h0, exl_out}, 32'h0);
    chk("eret_rpc", redirect_pc, 32'h80002000);
    chk("eret_rv", {31'h0, redirect_valid}, 32'h1);
    tick();
    chk("eret_drain_flush", {31'h0, flush}, 32'h1);
    // asynchronous reset in the middle of DRAIN
    #2 rst = 1'b1;
    #1;
    chk("arst_flush", {31'h0, flush}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_we", cp0_we, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_after_busy", {31'h0, busy}, 32'h0);
    $display("[TB] eret and async reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
